step_register: RTL and testbench
================================

Name: step_register

Overview:
- Parameterised N-bit data register with synchronous parallel load and single-step increment/decrement.
- Each inc/dec assertion moves the value by exactly one, however long the request is held, so slow control logic can drive inc/dec as levels.
- Asynchronous active-low reset clears the register.
- Used as a general-purpose datapath register: program counter, pointer or counter.

Parameters:
- DATA_SIZE, 11, width in bits of in, out and the internal register; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous reset, active-low; 0 clears state immediately.
- in  input  DATA_SIZE  parallel load data.
- load  input  1  level; while high, register takes in on every rising clk edge.
- inc  input  1  increment request; the 0->1 transition is the event.
- dec  input  1  decrement request; the 0->1 transition is the event.
- out  output  DATA_SIZE  registered value.
- is_zero  output  1  combinational; high when out == 0.
- is_max  output  1  combinational; high when out == all ones.

Behaviour:
- Reset: rst low forces out=0 and inc_q=dec_q=0 asynchronously, without waiting for a clock edge. While rst is low, out stays 0 regardless of other inputs. The first update occurs on the first rising clk edge with rst high.
- Edge detection: inc_q and dec_q register inc and dec on every clock edge.
  - inc_evt = inc & ~inc_q.
  - dec_evt = dec & ~dec_q.
  - Exactly one event per low-to-high transition, sampled at clk. A request high at reset release produces one event on the first edge.
- Priority per rising clk edge, highest first:
  1. load=1: out <= in. Any inc/dec events in that cycle are discarded, but inc_q and dec_q still update.
  2. inc_evt and dec_evt together: hold.
  3. inc_evt: out <= out + 1.
  4. dec_evt: out <= out - 1.
  5. otherwise: hold.
- Arithmetic is modulo 2^DATA_SIZE.
  - all ones + 1 -> 0.
  - 0 - 1 -> all ones.
  - No saturation; no carry output.
- Latency: out changes 1 cycle after the qualifying edge. Flags follow out combinationally.
- Held requests: inc or dec held high for many cycles causes exactly one step. It must drop low for at least one sampled edge before it can re-arm.
- Reset mid-operation: a pending edge or load is lost; out is 0 immediately.
- Inputs are assumed synchronous to clk; no internal synchroniser.

Test Plan:
- Load: DATA_SIZE=11, in=0x00A, load high for 2 edges -> out=0x00A at the following negedge; is_zero=0.
- Increment once: from 0x00A, inc high for 2+ edges -> out=0x00B; a further 5 held cycles leave 0x00B; drop inc then reassert -> 0x00C.
- Decrement and simultaneity: from 0x00C, dec pulse -> 0x00B.
  - inc and dec rising on the same edge -> stays 0x00B.
  - load with inc rising on the same edge -> out=in, no increment.
- Wrap-around:
  - Load 0x7FF, then inc event -> out=0x000, is_zero=1.
  - Dec event -> out=0x7FF, is_max=1.
- Async reset: with out=0x00B and dec high, drive rst low between clock edges -> out=0 within 1 ns with no clk edge. Hold dec high through reset release -> one decrement on the first edge, out=0x7FF.

Source files
------------

// File: rtl/step_register.sv
// step_register: N-bit datapath register with a synchronous parallel load and
// single-step increment and decrement.
//
// inc and dec are treated as level requests. Only their low-to-high transition,
// sampled at clk, moves the value, and it moves by exactly one. This lets slow
// control logic hold a request high for as long as it likes.
//
// Ports
//   clk      system clock; all updates happen on its rising edge
//   rst      asynchronous reset, active-low; clears value and edge history
//   in       parallel load data
//   load     level; while high, the register takes in on every rising edge
//   inc      increment request (rising transition is the event)
//   dec      decrement request (rising transition is the event)
//   out      registered value
//   is_zero  combinational, high when out == 0
//   is_max   combinational, high when out == all ones
module step_register #(
   parameter int unsigned DATA_SIZE = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_SIZE-1:0] in,
   input  logic                 load,
   input  logic                 inc,
   input  logic                 dec,
   output logic [DATA_SIZE-1:0] out,
   output logic                 is_zero,
   output logic                 is_max
);

   logic [DATA_SIZE-1:0] value_q, value_d;
   logic                 inc_q, dec_q;
   logic                 inc_evt, dec_evt;

   // inc_q and dec_q hold the previous request level. A request that is still
   // high after the first edge produces no further event.
   assign inc_evt = inc & ~inc_q;
   assign dec_evt = dec & ~dec_q;

   always_comb begin
      value_d = value_q;
      if (load) begin
         // Any event seen on this edge is discarded, not postponed.
         value_d = in;
      end else if (inc_evt && dec_evt) begin
         value_d = value_q;
      end else if (inc_evt) begin
         value_d = value_q + DATA_SIZE'(1);
      end else if (dec_evt) begin
         value_d = value_q - DATA_SIZE'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_q <= '0;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
      end else begin
         value_q <= value_d;
         // Edge history updates on every edge, including load cycles.
         inc_q   <= inc;
         dec_q   <= dec;
      end
   end

   assign out     = value_q;
   assign is_zero = (value_q == '0);
   assign is_max  = &value_q;

endmodule

// File: tb/tb_step_register.sv
module tb_step_register;

   localparam int unsigned W = 11;

   logic         clk;
   logic         rst;
   logic [W-1:0] in;
   logic         load;
   logic         inc;
   logic         dec;
   logic [W-1:0] out;
   logic         is_zero;
   logic         is_max;

   int errors = 0;
   int checks = 0;

   // Reference model: value as plain integer arithmetic modulo 2**W, plus the
   // request level seen on the previous edge.
   longint unsigned m_val;
   longint unsigned m_mask;
   bit              m_prev_inc;
   bit              m_prev_dec;

   step_register #(
      .DATA_SIZE(W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .in     (in),
      .load   (load),
      .inc    (inc),
      .dec    (dec),
      .out    (out),
      .is_zero(is_zero),
      .is_max (is_max)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model();
      check("out", 64'(out), m_val);
      check("is_zero", 64'(is_zero), 64'(m_val == 0));
      check("is_max", 64'(is_max), 64'(m_val == m_mask));
   endtask

   // Advance the model by one edge using the inputs currently applied, then
   // let the DUT take that edge and compare 1 ns later.
   task automatic tick();
      bit ie, de;
      if (!rst) begin
         m_val      = 0;
         m_prev_inc = 0;
         m_prev_dec = 0;
      end else begin
         ie = inc && !m_prev_inc;
         de = dec && !m_prev_dec;
         if (load)          m_val = longint'(in);
         else if (ie && de) m_val = m_val;
         else if (ie)       m_val = (m_val + 1) & m_mask;
         else if (de)       m_val = (m_val + m_mask) & m_mask;
         m_prev_inc = inc;
         m_prev_dec = dec;
      end
      @(posedge clk);
      #1;
      check_model();
   endtask

   initial begin
      m_mask     = (W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << W) - 1);
      m_val      = 0;
      m_prev_inc = 0;
      m_prev_dec = 0;
      rst  = 1'b0;
      in   = '0;
      load = 1'b0;
      inc  = 1'b0;
      dec  = 1'b0;

      #2;
      check("reset_out", 64'(out), 64'd0);
      tick();
      tick();
      rst = 1'b1;

      // Load
      in = W'(11'h00A); load = 1'b1;
      tick();
      tick();
      load = 1'b0;
      check("load_val", 64'(out), 64'h00A);
      check("load_nz", 64'(is_zero), 64'd0);

      // Held increment gives a single step; re-arming gives another
      inc = 1'b1;
      repeat (7) tick();
      check("inc_held", 64'(out), 64'h00B);
      inc = 1'b0;
      tick();
      inc = 1'b1;
      tick();
      check("inc_rearm", 64'(out), 64'h00C);
      inc = 1'b0;
      tick();

      // Decrement, simultaneous events, load priority
      dec = 1'b1;
      tick();
      dec = 1'b0;
      tick();
      check("dec_once", 64'(out), 64'h00B);
      inc = 1'b1; dec = 1'b1;
      tick();
      check("inc_dec_hold", 64'(out), 64'h00B);
      inc = 1'b0; dec = 1'b0;
      tick();
      in = W'(11'h123); load = 1'b1; inc = 1'b1;
      tick();
      check("load_over_inc", 64'(out), 64'h123);
      load = 1'b0;
      tick();
      check("inc_discarded", 64'(out), 64'h123);
      inc = 1'b0;
      tick();

      // Wrap-around in both directions
      in = W'(11'h7FF); load = 1'b1;
      tick();
      load = 1'b0;
      check("max_flag", 64'(is_max), 64'd1);
      inc = 1'b1;
      tick();
      check("wrap_up", 64'(out), 64'h000);
      check("wrap_up_zero", 64'(is_zero), 64'd1);
      inc = 1'b0;
      dec = 1'b1;
      tick();
      check("wrap_down", 64'(out), 64'h7FF);
      check("wrap_down_max", 64'(is_max), 64'd1);
      dec = 1'b0;
      tick();

      // Asynchronous reset between edges with dec held through release
      in = W'(11'h00B); load = 1'b1; dec = 1'b1;
      tick();
      load = 1'b0;
      tick();
      check("pre_reset", 64'(out), 64'h00B);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset", 64'(out), 64'd0);
      tick();
      rst = 1'b1;
      tick();
      check("dec_after_reset", 64'(out), 64'h7FF);
      dec = 1'b0;
      tick();

      // Randomized run against the model
      for (int i = 0; i < 600; i++) begin
         rst  = ($urandom_range(0, 49) != 0);
         load = ($urandom_range(0, 7) == 0);
         in   = W'($urandom);
         if ($urandom_range(0, 2) == 0) inc = ~inc;
         if ($urandom_range(0, 2) == 0) dec = ~dec;
         // Occasionally start near the wrap points
         if (load && $urandom_range(0, 3) == 0) in = $urandom_range(0, 1) ? '1 : '0;
         tick();
      end

      // Mid-cycle reset from a random state
      rst = 1'b1; load = 1'b1; in = W'($urandom) | W'(1);
      tick();
      load = 1'b0;
      #3;
      rst = 1'b0;
      #1;
      check("async_reset_rand", 64'(out), 64'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
